// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing one combinational sprite ROM among N_REQ burst requesters.
// Returned words form a registered stream tagged with the owning requester's index.
module rom_fetch_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4,
  parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_dout,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic [ID_W-1:0]         rd_id,
  output logic                    rd_last
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [ID_W-1:0]     rd_id_q, rd_id_d;
  logic                rd_last_q, rd_last_d;

  logic [ADDR_W-1:0]   addr_arr_s [N_REQ];
  logic [LEN_W-1:0]    len_arr_s  [N_REQ];
  logic                win_found_s;
  logic [ID_W-1:0]     win_idx_s;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr_s[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign len_arr_s[g]  = req_len[g*LEN_W +: LEN_W];
  end

  // Winner search: first set request starting at rr and wrapping modulo N_REQ.
  always_comb begin
    int unsigned idx;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (!win_found_s && req[idx]) begin
        win_found_s = 1'b1;
        win_idx_s   = ID_W'(idx);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/BURST controller.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    gnt_d      = '0;
    busy_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = '0;
    rd_id_d    = '0;
    rd_last_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d            = ST_BURST;
          owner_d            = win_idx_s;
          rom_addr_d         = addr_arr_s[win_idx_s];
          cnt_d              = len_arr_s[win_idx_s];
          gnt_d[win_idx_s]   = 1'b1;
          busy_d             = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        rd_data_d  = rom_dout;
        rd_valid_d = 1'b1;
        rd_id_d    = owner_q;
        rd_last_d  = (cnt_q == '0);
        rom_addr_d = rom_addr_q + ADDR_W'(1);
        cnt_d      = cnt_q - LEN_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          // Pointer moves past the finished owner so it ends up lowest priority.
          if (owner_q == ID_W'(N_REQ - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = owner_q + ID_W'(1);
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_id_q    <= rd_id_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign rom_addr = rom_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_id    = rd_id_q;
  assign rd_last  = rd_last_q;

endmodule
